// File: rtl/phase_sched_pkg.sv
// Shared types and defaults for the phase scheduler family.
// Optional emergency preemption is enabled with PHASE_SCHED_PREEMPT_EN.
package phase_sched_pkg;

  typedef enum logic [1:0] {
    PS_GREEN   = 2'd0,
    PS_YELLOW  = 2'd1,
    PS_ALL_RED = 2'd2
  } ps_state_e;

  localparam int DEF_N_PHASES  = 4;
  localparam int DEF_MIN_GREEN = 5;
  localparam int DEF_MAX_GREEN = 20;
  localparam int DEF_YELLOW_T  = 3;
  localparam int DEF_ALLRED_T  = 1;

  // Width of a phase index; at least one bit even for two phases.
  function automatic int phase_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_next_phase.sv
// Rotating-priority picker: first set bit of pending after cur_phase,
// wrapping modulo N_PHASES, with cur_phase itself examined last.
module rr_next_phase
  import phase_sched_pkg::*;
#(
  parameter int N_PHASES = DEF_N_PHASES
) (
  input  logic [N_PHASES-1:0]           pending,
  input  logic [phase_w(N_PHASES)-1:0]  cur_phase,
  output logic [phase_w(N_PHASES)-1:0]  next_phase,
  output logic                          valid
);

  localparam int PW = phase_w(N_PHASES);
  localparam int SW = PW + 2;

  logic [N_PHASES-1:0] rot;
  logic [PW-1:0]       rot_idx [N_PHASES];

  // rot[k] is the request of the phase k+1 places after cur_phase.
  for (genvar gi = 0; gi < N_PHASES; gi++) begin : g_rot
    logic [SW-1:0] sum;
    assign sum         = SW'(cur_phase) + SW'(gi + 1);
    assign rot_idx[gi] = (sum >= SW'(N_PHASES)) ? PW'(sum - SW'(N_PHASES)) : PW'(sum);
    assign rot[gi]     = pending[rot_idx[gi]];
  end

  always_comb begin
    next_phase = cur_phase;
    for (int k = N_PHASES - 1; k >= 0; k--) begin
      if (rot[k]) next_phase = rot_idx[k];
    end
    valid = |rot;
  end

endmodule

// File: rtl/phase_scheduler.sv
// Round-robin GREEN -> YELLOW -> ALL_RED scheduler for an N-approach junction.
// Define PHASE_SCHED_PREEMPT_EN to add emergency-vehicle preemption inputs.
module phase_scheduler
  import phase_sched_pkg::*;
#(
  parameter int N_PHASES  = DEF_N_PHASES,
  parameter int MIN_GREEN = DEF_MIN_GREEN,
  parameter int MAX_GREEN = DEF_MAX_GREEN,
  parameter int YELLOW_T  = DEF_YELLOW_T,
  parameter int ALLRED_T  = DEF_ALLRED_T
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tick,
  input  logic [N_PHASES-1:0]           req,
`ifdef PHASE_SCHED_PREEMPT_EN
  input  logic                          preempt,
  input  logic [phase_w(N_PHASES)-1:0]  preempt_phase,
`endif
  output logic [N_PHASES-1:0]           green,
  output logic [N_PHASES-1:0]           yellow,
  output logic                          all_red,
  output logic [phase_w(N_PHASES)-1:0]  cur_phase,
  output logic [N_PHASES-1:0]           pending,
  output logic                          phase_start
);

  localparam int PW = phase_w(N_PHASES);
  localparam int CW = $clog2(MAX_GREEN + 1);
  localparam logic [CW-1:0] MIN_C   = CW'(MIN_GREEN);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_GREEN);
  localparam logic [CW-1:0] MAX_M1  = CW'(MAX_GREEN - 1);
  localparam logic [CW-1:0] Y_LAST  = CW'(YELLOW_T - 1);
  localparam logic [CW:0]   AR_T    = (CW + 1)'(ALLRED_T);

  ps_state_e           state_q, state_d;
  logic [PW-1:0]       cur_phase_q, cur_phase_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N_PHASES-1:0] pending_q, pending_d;
  logic [N_PHASES-1:0] green_q, green_d;
  logic [N_PHASES-1:0] yellow_q, yellow_d;
  logic                all_red_q, all_red_d;
  logic                phase_start_q, phase_start_d;

  logic [N_PHASES-1:0] cur_mask, next_mask, others, req_set, grant_clr;
  logic [PW-1:0]       rr_phase, grant_phase;
  logic                rr_valid, gap_out, max_out, exit_green, yellow_done, ar_done, grant_go;

  rr_next_phase #(.N_PHASES(N_PHASES)) u_rr (
    .pending    (pending_q),
    .cur_phase  (cur_phase_q),
    .next_phase (rr_phase),
    .valid      (rr_valid)
  );

  for (genvar gi = 0; gi < N_PHASES; gi++) begin : g_mask
    assign cur_mask[gi]  = (cur_phase_q == PW'(gi));
    assign next_mask[gi] = (cur_phase_d == PW'(gi));
  end

  assign others      = pending_q & ~cur_mask;
  // The phase holding green serves its own detector instead of latching it.
  assign req_set     = req & ~((state_q == PS_GREEN) ? cur_mask : '0);
  assign gap_out     = (cnt_q >= MIN_C) && (|others) && !(|(req & cur_mask));
  assign max_out     = (|others) && ((cnt_q >= MAX_C) || (tick && (cnt_q == MAX_M1)));
  assign yellow_done = tick && (cnt_q == Y_LAST);
  assign ar_done     = tick && (({1'b0, cnt_q} + 1'b1) >= AR_T);

`ifdef PHASE_SCHED_PREEMPT_EN
  logic pre_hold;
  assign pre_hold    = preempt && (cur_phase_q == preempt_phase);
  assign exit_green  = (preempt && !pre_hold) || (!pre_hold && (gap_out || max_out));
  assign grant_go    = ar_done && (preempt || rr_valid);
  assign grant_phase = preempt ? preempt_phase : rr_phase;
`else
  assign exit_green  = gap_out || max_out;
  assign grant_go    = ar_done && rr_valid;
  assign grant_phase = rr_phase;
`endif

  always_comb begin
    state_d     = state_q;
    cur_phase_d = cur_phase_q;
    case (state_q)
      PS_GREEN:   if (exit_green)  state_d = PS_YELLOW;
      PS_YELLOW:  if (yellow_done) state_d = PS_ALL_RED;
      PS_ALL_RED: if (grant_go) begin
        state_d     = PS_GREEN;
        cur_phase_d = grant_phase;
      end
      default:    state_d = PS_GREEN;
    endcase
  end

  always_comb begin
    phase_start_d = (state_q == PS_ALL_RED) && (state_d == PS_GREEN);
    grant_clr     = phase_start_d ? next_mask : '0;
    pending_d     = (pending_q | req_set) & ~grant_clr;
    if (state_d != state_q)            cnt_d = '0;
    else if (tick && (cnt_q != MAX_C)) cnt_d = cnt_q + 1'b1;
    else                               cnt_d = cnt_q;
    green_d   = (state_d == PS_GREEN)  ? next_mask : '0;
    yellow_d  = (state_d == PS_YELLOW) ? next_mask : '0;
    all_red_d = (state_d == PS_ALL_RED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= PS_GREEN;
      cur_phase_q   <= '0;
      cnt_q         <= '0;
      pending_q     <= '0;
      green_q       <= N_PHASES'(1);
      yellow_q      <= '0;
      all_red_q     <= 1'b0;
      phase_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_phase_q   <= cur_phase_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      green_q       <= green_d;
      yellow_q      <= yellow_d;
      all_red_q     <= all_red_d;
      phase_start_q <= phase_start_d;
    end
  end

  assign green       = green_q;
  assign yellow      = yellow_q;
  assign all_red     = all_red_q;
  assign cur_phase   = cur_phase_q;
  assign pending     = pending_q;
  assign phase_start = phase_start_q;

endmodule

// File: tb/tb_phase_scheduler.sv
// Directed bench for phase_scheduler (N=4, MIN=5, MAX=20, Y=3, AR=1).
// Observation vector: {green, yellow, all_red, phase_start, pending, cur_phase}.
module tb_phase_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [3:0] req;
  logic [3:0] green, yellow, pending;
  logic       all_red, phase_start;
  logic [1:0] cur_phase;
`ifdef PHASE_SCHED_PREEMPT_EN
  logic       preempt;
  logic [1:0] preempt_phase;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int ycnt        = 0;
  logic ok;

  phase_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .req         (req),
`ifdef PHASE_SCHED_PREEMPT_EN
    .preempt       (preempt),
    .preempt_phase (preempt_phase),
`endif
    .green       (green),
    .yellow      (yellow),
    .all_red     (all_red),
    .cur_phase   (cur_phase),
    .pending     (pending),
    .phase_start (phase_start)
  );

  always #5 clk = ~clk;

  wire [15:0] obs = {green, yellow, all_red, phase_start, pending, cur_phase};

  function automatic logic [15:0] vec(input logic [3:0] g, input logic [3:0] y,
                                      input logic ar, input logic ps,
                                      input logic [3:0] pend, input logic [1:0] cur);
    return {g, y, ar, ps, pend, cur};
  endfunction

  task automatic check(input string tag, input logic [15:0] o, input logic [15:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input string tag, input logic [15:0] e);
    step();
    check(tag, obs, e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    tick  = 1'b1;
`ifdef PHASE_SCHED_PREEMPT_EN
    preempt       = 1'b0;
    preempt_phase = 2'd0;
`endif
    step();
    step();
    check("reset", obs, vec(4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0));
    reset = 1'b0;
  endtask

  initial begin
    // Idle rest on phase 0
    do_reset();
    repeat (100) step_chk("idle", vec(4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0));

    // Gap-out to phase 2
    do_reset();
    req = 4'b0100;
    step_chk("gap_latch", vec(4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0100, 2'd0));
    req = 4'b0000;
    repeat (4) step_chk("gap_green", vec(4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0100, 2'd0));
    repeat (3) step_chk("gap_yellow", vec(4'b0000, 4'b0001, 1'b0, 1'b0, 4'b0100, 2'd0));
    step_chk("gap_allred", vec(4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0100, 2'd0));
    step_chk("gap_grant", vec(4'b0100, 4'b0000, 1'b0, 1'b1, 4'b0000, 2'd2));
    step_chk("gap_hold", vec(4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2));

    // Max-out with own request held
    do_reset();
    req = 4'b0011;
    step_chk("max_latch", vec(4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0010, 2'd0));
    req = 4'b0001;
    repeat (18) step_chk("max_green", vec(4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0010, 2'd0));
    step_chk("max_yellow0", vec(4'b0000, 4'b0001, 1'b0, 1'b0, 4'b0010, 2'd0));
    repeat (2) step_chk("max_yellow", vec(4'b0000, 4'b0001, 1'b0, 1'b0, 4'b0011, 2'd0));
    step_chk("max_allred", vec(4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0011, 2'd0));
    step_chk("max_grant", vec(4'b0010, 4'b0000, 1'b0, 1'b1, 4'b0001, 2'd1));

    // Wrap-around order from phase 1: phase 3 then phase 0
    req = 4'b1001;
    step_chk("wrap_latch", vec(4'b0010, 4'b0000, 1'b0, 1'b0, 4'b1001, 2'd1));
    req = 4'b0000;
    repeat (4) step_chk("wrap_green1", vec(4'b0010, 4'b0000, 1'b0, 1'b0, 4'b1001, 2'd1));
    repeat (3) step_chk("wrap_yellow1", vec(4'b0000, 4'b0010, 1'b0, 1'b0, 4'b1001, 2'd1));
    step_chk("wrap_allred1", vec(4'b0000, 4'b0000, 1'b1, 1'b0, 4'b1001, 2'd1));
    step_chk("wrap_grant3", vec(4'b1000, 4'b0000, 1'b0, 1'b1, 4'b0001, 2'd3));
    repeat (5) step_chk("wrap_green3", vec(4'b1000, 4'b0000, 1'b0, 1'b0, 4'b0001, 2'd3));
    repeat (3) step_chk("wrap_yellow3", vec(4'b0000, 4'b1000, 1'b0, 1'b0, 4'b0001, 2'd3));
    step_chk("wrap_allred3", vec(4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0001, 2'd3));
    step_chk("wrap_grant0", vec(4'b0001, 4'b0000, 1'b0, 1'b1, 4'b0000, 2'd0));

    // Slow timebase: tick on every 4th clk
    do_reset();
    ycnt = 0;
    for (int k = 1; k <= 44; k++) begin
      tick = ((k % 4) == 0);
      req  = (k == 23) ? 4'b1000 : 4'b0000;
      step();
      ok = $onehot0(green) && $onehot0(yellow) && !((|green) && (|yellow));
      check("tick_excl", {15'd0, ok}, 16'd1);
      if (|yellow) ycnt++;
      if (k == 24) check("tick_yellow_start", obs, vec(4'b0000, 4'b0001, 1'b0, 1'b0, 4'b1000, 2'd0));
      if (k == 36) check("tick_allred", obs, vec(4'b0000, 4'b0000, 1'b1, 1'b0, 4'b1000, 2'd0));
      if (k == 40) check("tick_grant", obs, vec(4'b1000, 4'b0000, 1'b0, 1'b1, 4'b0000, 2'd3));
    end
    check("tick_yellow_len", 16'(ycnt), 16'd12);
    tick = 1'b1;

    // Reset taken in the middle of yellow
    do_reset();
    req = 4'b1010;
    step_chk("rst_latch", vec(4'b0001, 4'b0000, 1'b0, 1'b0, 4'b1010, 2'd0));
    req = 4'b0000;
    repeat (4) step_chk("rst_green", vec(4'b0001, 4'b0000, 1'b0, 1'b0, 4'b1010, 2'd0));
    repeat (2) step_chk("rst_yellow", vec(4'b0000, 4'b0001, 1'b0, 1'b0, 4'b1010, 2'd0));
    reset = 1'b1;
    step_chk("rst_mid", vec(4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0));
    reset = 1'b0;

`ifdef PHASE_SCHED_PREEMPT_EN
    // Emergency preemption to phase 2
    do_reset();
    step_chk("pre_g0", vec(4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0));
    preempt       = 1'b1;
    preempt_phase = 2'd2;
    repeat (3) step_chk("pre_yellow", vec(4'b0000, 4'b0001, 1'b0, 1'b0, 4'b0000, 2'd0));
    step_chk("pre_allred", vec(4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0));
    step_chk("pre_grant", vec(4'b0100, 4'b0000, 1'b0, 1'b1, 4'b0000, 2'd2));
    req = 4'b0001;
    step_chk("pre_latch", vec(4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0001, 2'd2));
    req = 4'b0000;
    repeat (25) step_chk("pre_hold", vec(4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0001, 2'd2));
    preempt = 1'b0;
    step_chk("pre_release", vec(4'b0000, 4'b0100, 1'b0, 1'b0, 4'b0001, 2'd2));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/phase_scheduler.md
Name: phase_scheduler

Overview:
- Round-robin phase scheduler for an N-approach signalised intersection.
- Latches vehicle detector requests and grants one approach green at a time.
- Sequences GREEN -> YELLOW -> ALL_RED -> next GREEN using min/max green, yellow and all-red clearance times counted in ticks.
- Sits above the per-approach lamp drivers and replaces the fixed two-road controller wherever more than two approaches share the junction.

Parameters:
- N_PHASES, 4, number of approaches/phases (2..8).
- MIN_GREEN, 5, ticks of guaranteed green before gap-out is allowed.
- MAX_GREEN, 20, ticks after which green is forced to end if another phase is pending (MAX_GREEN > MIN_GREEN).
- YELLOW_T, 3, yellow duration in ticks (>=1).
- ALLRED_T, 1, all-red clearance in ticks (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- tick  in  1  single-cycle timebase enable (e.g. 1 Hz strobe); all durations count tick cycles
- req  in  N_PHASES  level vehicle-detector request per approach
- green  out  N_PHASES  one-hot green lamp enable, zero outside GREEN
- yellow  out  N_PHASES  one-hot yellow enable for the phase being terminated
- all_red  out  1  high during ALL_RED clearance
- cur_phase  out  clog2(N_PHASES)  phase currently owning GREEN/YELLOW, or last-served phase during ALL_RED
- pending  out  N_PHASES  latched request vector
- phase_start  out  1  one-cycle pulse on the clk edge a new GREEN begins

Behaviour:
- States: GREEN, YELLOW, ALL_RED.
- Counter cnt is cleared on every state entry and increments on clk when tick=1. It saturates at MAX_GREEN.
- Reset values:
  - state=GREEN, cur_phase=0, cnt=0, pending=0.
  - green=1 on bit 0, yellow=0, all_red=0, phase_start=0.
  - Reset is taken mid-operation with no drain.
- Request latch:
  - pending[i] is set when req[i]=1, unless state=GREEN and cur_phase=i (own requests are served, not latched).
  - pending[i] is cleared on the edge that enters GREEN for phase i; clear wins over a simultaneous set.
- "others" = pending with bit cur_phase masked.
- GREEN exit to YELLOW, evaluated every clk:
  - Gap-out: cnt>=MIN_GREEN, others!=0 and req[cur_phase]=0.
  - Max-out: others!=0 and (cnt>=MAX_GREEN, or tick=1 with cnt==MAX_GREEN-1).
  - If others==0, the block rests in green indefinitely; cnt saturates.
- YELLOW -> ALL_RED on the clk edge where tick=1 and cnt==YELLOW_T-1.
- ALL_RED -> GREEN on the clk edge where tick=1 and cnt>=ALLRED_T-1 and pending!=0.
  - The granted phase is the first set bit of pending scanning cur_phase+1, cur_phase+2, ... with mod-N wrap. This includes cur_phase itself last.
  - If pending==0, the block stays in ALL_RED until a request arrives. That request is granted no earlier than the edge after it is latched.
- Output timing:
  - Outputs are registered and change on the same edge as the state.
  - phase_start=1 for exactly the first GREEN cycle after ALL_RED; it is not asserted after reset.
- Single-phase requests while resting (pending==others==0) never create yellow.

Optional Feature:
- Macro: PHASE_SCHED_PREEMPT_EN.
- With the macro defined:
  - Adds inputs preempt (1) and preempt_phase (clog2(N_PHASES)) for emergency vehicles.
  - preempt=1 in GREEN of a different phase -> YELLOW on the next edge, ignoring MIN_GREEN.
  - ALL_RED exit grants preempt_phase regardless of round-robin order and pending.
  - While preempt=1 and green is on preempt_phase, no exit occurs.
  - Round-robin resumes from preempt_phase after preempt drops.
- Without the macro, these ports are absent and behaviour is exactly as above.

Decomposition:
- Package phase_sched_pkg:
  - state typedef enum (PS_GREEN, PS_YELLOW, PS_ALL_RED).
  - Default timing constants.
  - Phase-index width function.
- Sub-module rr_next_phase: combinational rotate-priority picker.
  - Inputs: pending vector, cur_phase.
  - Outputs: next index and valid.
  - Reused by future pedestrian-phase scheduler.

Test Plan:
All cases use N_PHASES=4, MIN=5, MAX=20, Y=3, AR=1, tick=1 every clk unless noted.
- Reset then idle 100 cycles -> green=0001 throughout, yellow=0, all_red=0, phase_start never high.
- req[2] pulsed 1 cycle after reset -> pending=0100.
  - Gap-out after 5 ticks of green0, then yellow=0001 for 3 cycles, then all_red for 1 cycle.
  - Then green=0100, phase_start 1 cycle, pending=0000.
- req[0] held high with req[1] pulsed -> green0 lasts 20 cycles (max-out), then yellow0, then green=0010.
- From green on phase 1 with req[0] and req[3] pulsed together -> grant order phase 3 then phase 0 (wrap).
- tick every 4th clk with req[3] pulsed -> yellow held 12 clks; green/yellow are always one-hot or zero and never both nonzero.
- Reset asserted mid-YELLOW with pending=1010 -> next edge green=0001, pending=0000, all_red=0.
  - With PHASE_SCHED_PREEMPT_EN, preempt=1 and preempt_phase=2 at cnt=1 of green0 -> immediate yellow0, then green=0100 held while preempt high.
